// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-entry holding register.
// Optional 3-sample majority glitch filter, enabled by defining UART_RX_GLITCH_FILTER_EN.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output logic [1:0]            state_o
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int IDX_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  sync1_q, sync2_q;
  logic                  rxd_s;
  logic                  sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;

`ifdef UART_RX_GLITCH_FILTER_EN
  // Majority of the current and two previous synchronized values rejects 1-cycle spikes.
  logic [1:0] filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 2'b11;
    end else begin
      filt_q <= {filt_q[0], rxd_s};
    end
  end

  assign sample = (rxd_s & filt_q[0]) | (rxd_s & filt_q[1]) | (filt_q[0] & filt_q[1]);
`else
  assign sample = rxd_s;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!sample) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!sample) begin
            state_d = S_DATA;
            cnt_d   = CNT_FULL;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = sample;
          cnt_d          = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (sample) begin
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a monitor scoreboards every accepted byte.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [1:0] state_o;

  int         total = 0;
  int         bad   = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] glitch_exp;

  uart_rx #(
    .DATA_WIDTH(8),
    .BAUD_RATE (1),
    .CLK_FREQ  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy),
    .state_o  (state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected queue on every accepted byte, checks hold stability, counts pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (prev_hold) check("data_stable", {24'd0, data}, {24'd0, prev_data});
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none", data);
        end else begin
          check("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_hold = valid && !ready;
      prev_data = data;
    end
  end

  // Drivers
  task automatic drive_bit(input logic b, input int spike_at);
    for (int j = 0; j < 16; j++) begin
      rxd = (j == spike_at) ? ~b : b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == spike_bit) ? 8 : -1);
    drive_bit(stop, -1);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
`ifdef UART_RX_GLITCH_FILTER_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h04;
`endif
    rxd   = 1'b1;
    ready = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data", {24'd0, data}, 32'h0);
    check("reset_valid", {31'd0, valid}, 32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    check("reset_overrun", {31'd0, overrun}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1;

    // Good frame, consumer ready
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    idle(20);
    check("a5_frame_err_cnt", fe_cnt, 0);
    check("a5_overrun_cnt", ov_cnt, 0);
    check("a5_drained", exp_q.size(), 0);

    // Bad stop bit
    send_frame(8'h3C, 1'b0, -1);
    idle(30);
    check("3c_frame_err_cnt", fe_cnt, 1);
    check("3c_valid", {31'd0, valid}, 32'h0);
    check("3c_busy", {31'd0, busy}, 32'h0);

    // 3-cycle low spike on idle line
    rxd = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("false_start_busy", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1;
    idle(10);
    check("false_start_frame_err_cnt", fe_cnt, 1);
    check("false_start_valid", {31'd0, valid}, 32'h0);

    // Back-to-back with consumer stalled
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(20);
    check("ovr_valid_held", {31'd0, valid}, 32'h1);
    check("ovr_data_held", {24'd0, data}, 32'h11);
    check("ovr_overrun_cnt", ov_cnt, 1);
    ready = 1'b1;
    idle(3);
    check("ovr_valid_drop", {31'd0, valid}, 32'h0);
    check("ovr_drained", exp_q.size(), 0);

    // Reset during data bit 4 of 0xFF
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
    idle(8);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_data", {24'd0, data}, 32'h0);
    check("rst_mid_valid", {31'd0, valid}, 32'h0);
    check("rst_mid_frame_err", {31'd0, frame_err}, 32'h0);
    check("rst_mid_overrun", {31'd0, overrun}, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1;
    idle(30);
    check("rst_mid_frame_err_cnt", fe_cnt, 1);
    check("rst_mid_overrun_cnt", ov_cnt, 1);
    ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    idle(5);
    check("5a_valid", {31'd0, valid}, 32'h1);
    check("5a_data", {24'd0, data}, 32'h5A);
    ready = 1'b1;
    idle(3);

    // 1-cycle spike at the sample point of data bit 2
    exp_q.push_back(glitch_exp);
    send_frame(8'h00, 1'b1, 2);
    idle(20);
    check("final_drained", exp_q.size(), 0);
    check("final_frame_err_cnt", fe_cnt, 1);
    check("final_overrun_cnt", ov_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
